// File: rtl/prog_loader.sv
// Program-memory writer: takes a length-prefixed, checksummed byte stream and
// writes WIDTH-bit words into program memory while holding the CPU in reset.
module prog_loader #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 1024,
  localparam int AW    = $clog2(NWORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             we,
  output logic [AW-1:0]    wa,
  output logic [WIDTH-1:0] wd,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      words_loaded
);

  localparam int BPW = WIDTH / 8;
  localparam logic [7:0] BPW_M1 = 8'(BPW - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             we_q, we_d;
  logic [AW-1:0]    wa_q, wa_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic             hold_q, hold_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [15:0]      wl_q, wl_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic [7:0]       bcnt_q, bcnt_d;
  logic [7:0]       csum_q, csum_d;

  logic             xfer;
  logic [15:0]      len_full;
  logic [WIDTH-1:0] asm_shift;
  logic             word_end;
  logic             last_word;

  assign xfer      = in_valid && in_ready_q;
  assign len_full  = {len_q[15:8], in_data};
  assign asm_shift = WIDTH'({asm_q, in_data});
  assign word_end  = (bcnt_q == BPW_M1);
  assign last_word = (wcnt_q == len_q - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      asm_q      <= '0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wl_q       <= '0;
      len_q      <= '0;
      wcnt_q     <= '0;
      bcnt_q     <= '0;
      csum_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      asm_q      <= asm_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wl_q       <= wl_d;
      len_q      <= len_d;
      wcnt_q     <= wcnt_d;
      bcnt_q     <= bcnt_d;
      csum_q     <= csum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LEN_HI;
      S_LEN_HI: if (xfer) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (int'(len_full) > NWORDS) state_d = S_ERR;
          else if (len_full == 16'd0)  state_d = S_CHECK;
          else                         state_d = S_DATA;
        end
      end
      S_DATA:   if (xfer && word_end && last_word) state_d = S_CHECK;
      S_CHECK:  if (xfer) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      S_DONE:   state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    we_d   = 1'b0;
    wa_d   = wa_q;
    wd_d   = wd_q;
    asm_d  = asm_q;
    hold_d = hold_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d  = err_q;
    wl_d   = wl_q;
    len_d  = len_q;
    wcnt_d = wcnt_q;
    bcnt_d = bcnt_q;
    csum_d = csum_q;
    in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                 (state_d == S_DATA)   || (state_d == S_CHECK);
    // The address and count advance once the write cycle has been presented.
    if (we_q) begin
      wa_d = wa_q + AW'(1);
      wl_d = wl_q + 16'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          wl_d   = '0;
          csum_d = '0;
          wa_d   = '0;
          len_d  = '0;
          wcnt_d = '0;
          bcnt_d = '0;
          busy_d = 1'b1;
          hold_d = 1'b1;
        end
      end
      S_LEN_HI: if (xfer) len_d[15:8] = in_data;
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = in_data;
          if (int'(len_full) > NWORDS) begin
            err_d  = 1'b1;
            busy_d = 1'b0;
            hold_d = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          csum_d = csum_q + in_data;
          asm_d  = asm_shift;
          if (word_end) begin
            bcnt_d = '0;
            wd_d   = asm_shift;
            we_d   = 1'b1;
            wcnt_d = wcnt_q + 16'd1;
          end else begin
            bcnt_d = bcnt_q + 8'd1;
          end
        end
      end
      S_CHECK: begin
        if (xfer) begin
          done_d = (in_data == csum_q);
          err_d  = (in_data != csum_q);
          busy_d = 1'b0;
          hold_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign in_ready     = in_ready_q;
  assign we           = we_q;
  assign wa           = wa_q;
  assign wd           = wd_q;
  assign cpu_hold     = hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = wl_q;

endmodule
